// File: rtl/seg7_pkg.sv
// seg7_capture shared types: segment patterns (a..g on [6:0], low = lit),
// BCD code type and output FSM states.
package seg7_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0 = 7'b0000001;
  localparam seg_t SEG_1 = 7'b1001111;
  localparam seg_t SEG_2 = 7'b0010010;
  localparam seg_t SEG_3 = 7'b0000110;
  localparam seg_t SEG_4 = 7'b1001100;
  localparam seg_t SEG_5 = 7'b0100100;
  localparam seg_t SEG_6 = 7'b0100000;
  localparam seg_t SEG_7 = 7'b0001101;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0000100;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam bcd_t BCD_BLANK = 4'hF;

  typedef enum logic {
    ST_COLLECT,
    ST_PRESENT
  } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to BCD decoder.
// SEG7_CAPTURE_BLANK_EN makes the all-off pattern decode to BCD_BLANK.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  seg_t seg_i,
  output bcd_t code_o,
  output logic valid_o
);

  always_comb begin
    code_o  = '0;
    valid_o = 1'b1;
    case (seg_i)
      SEG_0:     code_o = 4'd0;
      SEG_1:     code_o = 4'd1;
      SEG_2:     code_o = 4'd2;
      SEG_3:     code_o = 4'd3;
      SEG_4:     code_o = 4'd4;
      SEG_5:     code_o = 4'd5;
      SEG_6:     code_o = 4'd6;
      SEG_7:     code_o = 4'd7;
      SEG_8:     code_o = 4'd8;
      SEG_9:     code_o = 4'd9;
`ifdef SEG7_CAPTURE_BLANK_EN
      SEG_BLANK: code_o = BCD_BLANK;
`endif
      default:   valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Multiplexed 7-segment bus capture: per-digit stability filter, frame
// assembly, valid/ready output. Option macro: SEG7_CAPTURE_BLANK_EN.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun
);

  localparam int DW = 4*NUM_DIGITS;
  localparam logic [3:0] STABLE = 4'(STABLE_CNT);

  seg_t                  seg_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic [NUM_DIGITS-1:0] sel;
  logic                  sel_ok;
  bcd_t                  code;
  logic                  code_ok;

  bcd_t            last_q [NUM_DIGITS];
  bcd_t            last_d [NUM_DIGITS];
  logic [3:0]      cnt_q  [NUM_DIGITS];
  logic [3:0]      cnt_d  [NUM_DIGITS];
  logic [DW-1:0]   buf_q, buf_d;
  logic [NUM_DIGITS-1:0] done_q, done_d;
  logic            err_q, err_d;
  logic            complete;

  state_e          state_q, state_d;
  logic [DW-1:0]   bcd_q, bcd_d;
  logic            oerr_q, oerr_d;
  logic            ovr_q, ovr_d;

  seg7_pattern_decode u_dec (
    .seg_i   (seg_q),
    .code_o  (code),
    .valid_o (code_ok)
  );

  assign sel      = ~an_q;
  assign sel_ok   = $onehot(sel);
  assign complete = &done_q;

  // A completing frame releases done_mask this cycle, so an acceptance
  // landing on the same edge already belongs to the next frame.
  always_comb begin
    last_d = last_q;
    cnt_d  = cnt_q;
    buf_d  = buf_q;
    done_d = complete ? '0 : done_q;
    err_d  = complete ? 1'b0 : err_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_ok && sel[i]) begin
        if (!code_ok) begin
          cnt_d[i] = '0;
          err_d    = 1'b1;
        end else if (code == last_q[i]) begin
          if (cnt_q[i] != STABLE) cnt_d[i] = cnt_q[i] + 4'd1;
        end else begin
          last_d[i] = code;
          cnt_d[i]  = 4'd1;
        end
        if (code_ok && cnt_d[i] == STABLE &&
            (cnt_q[i] != STABLE || code != last_q[i]) &&
            !(done_q[i] && !complete)) begin
          buf_d[4*i +: 4] = code;
          done_d[i]       = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    oerr_d  = oerr_q;
    ovr_d   = 1'b0;
    unique case (state_q)
      ST_COLLECT: begin
        if (complete) begin
          bcd_d   = buf_q;
          oerr_d  = err_q;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (out_ready) begin
          if (complete) begin
            bcd_d  = buf_q;
            oerr_d = err_q;
          end else begin
            state_d = ST_COLLECT;
          end
        end else if (complete) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q   <= SEG_BLANK;
      an_q    <= '1;
      buf_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      state_q <= ST_COLLECT;
      bcd_q   <= '0;
      oerr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        last_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      seg_q   <= seg_in;
      an_q    <= an_in;
      buf_q   <= buf_d;
      done_q  <= done_d;
      err_q   <= err_d;
      state_q <= state_d;
      bcd_q   <= bcd_d;
      oerr_q  <= oerr_d;
      ovr_q   <= ovr_d;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        last_q[i] <= last_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  assign bcd_out   = bcd_q;
  assign out_err   = oerr_q;
  assign out_valid = (state_q == ST_PRESENT);
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture (NUM_DIGITS=4, STABLE_CNT=3,
// SEG7_CAPTURE_BLANK_EN undefined).
module tb_seg7_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] bcd_out;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  int n_chk  = 0;
  int n_pass = 0;
  int n_ovr  = 0;
  int ovr0;

  logic [16:0] fq[$];
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [15:0] pb = '0;
  logic        pe = 1'b0;

  always #5 clk = ~clk;

  seg7_capture #(
    .NUM_DIGITS (4),
    .STABLE_CNT (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .an_in     (an_in),
    .bcd_out   (bcd_out),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001101;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // Frame capture, overrun counting and hold-stability checks.
  always begin
    @(negedge clk);
    #1;
    if (out_valid && out_ready) fq.push_back({out_err, bcd_out});
    if (overrun) n_ovr++;
    if (out_valid && pv && !pr) begin
      chk("hold_bcd", 32'(bcd_out), 32'(pb));
      chk("hold_err", 32'(out_err), 32'(pe));
    end
    pv = out_valid;
    pr = out_ready;
    pb = bcd_out;
    pe = out_err;
  end

  task automatic show(input int d, input logic [6:0] p, input int n);
    for (int k = 0; k < n; k++) begin
      an_in  = ~(4'b0001 << d);
      seg_in = p;
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    an_in = 4'b1111;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] v);
    for (int d = 0; d < 4; d++) show(d, pat(int'(v[4*d +: 4])), 3);
  endtask

  task automatic expect_frame(input string tag, input logic [15:0] eb,
                              input logic ee);
    logic [16:0] f;
    int t = 0;
    while (fq.size() == 0 && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_arrived"}, 32'(fq.size() != 0), 32'd1);
    if (fq.size() != 0) begin
      f = fq.pop_front();
      chk({tag, "_bcd"}, 32'(f[15:0]), 32'(eb));
      chk({tag, "_err"}, 32'(f[16]), 32'(ee));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    an_in     = 4'b1111;
    seg_in    = 7'b1111111;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_bcd", 32'(bcd_out), 32'h0);
    chk("rst_err", 32'(out_err), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Round-robin 1,2,3,4 with exact output latency.
    out_ready = 1'b1;
    show(0, pat(1), 3);
    show(1, pat(2), 3);
    show(2, pat(3), 3);
    show(3, pat(4), 3);
    an_in = 4'b1111;
    @(negedge clk);
    chk("lat_early", 32'(out_valid), 32'h0);
    @(negedge clk);
    chk("lat_valid", 32'(out_valid), 32'h1);
    chk("lat_bcd", 32'(bcd_out), 32'h4321);
    chk("lat_err", 32'(out_err), 32'h0);
    @(negedge clk);
    chk("lat_drop", 32'(out_valid), 32'h0);
    expect_frame("f1", 16'h4321, 1'b0);

    // Digit 0 settles on 3 after a short run of 2.
    show(0, pat(2), 2);
    show(0, pat(3), 3);
    show(1, pat(5), 3);
    show(2, pat(6), 3);
    show(3, pat(7), 3);
    idle(1);
    expect_frame("f2", 16'h7653, 1'b0);

    // Bad pattern on digit 2 flags the frame.
    show(0, pat(8), 3);
    show(1, pat(9), 3);
    show(2, pat(0), 1);
    show(2, 7'b1111110, 1);
    show(2, pat(0), 3);
    show(3, pat(1), 3);
    idle(1);
    expect_frame("f3", 16'h1098, 1'b1);

    send_frame(16'h5432);
    idle(1);
    expect_frame("f4", 16'h5432, 1'b0);

    // All-off pattern is invalid in the default build.
    show(0, pat(6), 3);
    show(1, pat(7), 1);
    show(1, 7'b1111111, 1);
    show(1, pat(7), 3);
    show(2, pat(8), 3);
    show(3, pat(9), 3);
    idle(1);
    expect_frame("f5", 16'h9876, 1'b1);

    // Multi-select and no-select samples are ignored.
    show(0, pat(1), 3);
    show(1, pat(2), 1);
    an_in  = 4'b1100;
    seg_in = pat(8);
    repeat (5) @(negedge clk);
    an_in = 4'b1111;
    repeat (5) @(negedge clk);
    show(1, pat(2), 2);
    show(2, pat(3), 3);
    show(3, pat(4), 3);
    idle(1);
    expect_frame("f6", 16'h4321, 1'b0);

    // Backpressure across two frames: hold first, drop second.
    out_ready = 1'b0;
    send_frame(16'h8765);
    idle(4);
    chk("bp_valid", 32'(out_valid), 32'h1);
    chk("bp_bcd", 32'(bcd_out), 32'h8765);
    ovr0 = n_ovr;
    send_frame(16'h3210);
    idle(4);
    chk("bp_ovr_once", 32'(n_ovr - ovr0), 32'd1);
    chk("bp_valid2", 32'(out_valid), 32'h1);
    chk("bp_bcd2", 32'(bcd_out), 32'h8765);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_hs_drop", 32'(out_valid), 32'h0);
    expect_frame("f7", 16'h8765, 1'b0);
    idle(3);
    chk("bp_no_stale", 32'(out_valid), 32'h0);

    // Asynchronous reset while presenting.
    send_frame(16'h6789);
    idle(4);
    chk("pre_rst_valid", 32'(out_valid), 32'h1);
    chk("pre_rst_bcd", 32'(bcd_out), 32'h6789);
    rst_n = 1'b0;
    #1;
    chk("arst_bcd", 32'(bcd_out), 32'h0);
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_err", 32'(out_err), 32'h0);
    chk("arst_ovr", 32'(overrun), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    chk("post_rst_idle", 32'(out_valid), 32'h0);
    out_ready = 1'b1;
    show(0, pat(1), 3);
    show(1, pat(2), 3);
    show(2, pat(3), 3);
    idle(5);
    chk("partial_frame", 32'(out_valid), 32'h0);
    show(3, pat(4), 3);
    idle(1);
    expect_frame("f8", 16'h4321, 1'b0);
    chk("no_extra", 32'(fq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
